banco_reg_param: RTL and testbench

Parametrised successor to the 4x32 register bank. It provides N_REGS registers of LARGURA bits, with one synchronous write port and two combinational read ports. Register 0 is hardwired to zero, and an optional write-to-read bypass is available. A per-register pending scoreboard lets the datapath control stall reads of registers that still await a writeback. It sits between decode (read sources, destination marking) and writeback (write port).

---
 rtl/banco_reg_param.sv | 110 +++++++++++
 tb/tb_banco_reg_param.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/banco_reg_param.sv
// rtl/banco_reg_param.sv - parametrised register bank with r0 hardwired, optional write bypass and pending scoreboard
//
// Purpose:
//   N_REGS registers of LARGURA bits. One synchronous write port (writeback),
//   two combinational read ports (decode), and a per-register pending bit
//   that lets the datapath stall a read whose producer has not written back.
//
// Ports:
//   clk, rst              clock and synchronous active-high reset
//   reg_e, e_l, dado      writeback destination, write enable, write data
//   fnt1, fnt2            read source addresses
//   dado_l_1, dado_l_2    read data (combinational)
//   reg_pend, marca_pend  destination being issued by decode, mark enable
//   ocupado_1, ocupado_2  read source still awaiting its writeback
//   pendentes             raw pending bit vector

module banco_reg_param #(
    parameter int LARGURA = 32,
    parameter int N_REGS  = 8,
    parameter int END     = $clog2(N_REGS),
    parameter bit BYPASS  = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [END-1:0]     reg_e,
    input  logic               e_l,
    input  logic [LARGURA-1:0] dado,
    input  logic [END-1:0]     fnt1,
    input  logic [END-1:0]     fnt2,
    output logic [LARGURA-1:0] dado_l_1,
    output logic [LARGURA-1:0] dado_l_2,
    input  logic [END-1:0]     reg_pend,
    input  logic               marca_pend,
    output logic               ocupado_1,
    output logic               ocupado_2,
    output logic [N_REGS-1:0]  pendentes
);

    // Register count held in END+1 bits so address comparisons are width-matched.
    localparam logic [END:0] L_NREGS = (END+1)'(N_REGS);

    logic [LARGURA-1:0] r_regs [N_REGS];
    logic [N_REGS-1:0]  r_pend;
    logic [N_REGS-1:0]  w_pend_next;

    logic w_wr_ok;
    logic w_mark_ok;
    logic w_ok1;
    logic w_ok2;
    logic w_byp1;
    logic w_byp2;

    // An address is usable when it is nonzero and inside the bank; r0 and
    // the unused codes of a non-power-of-two bank read as zero and ignore writes.
    assign w_wr_ok   = e_l && (reg_e != '0) && ({1'b0, reg_e} < L_NREGS);
    assign w_mark_ok = marca_pend && (reg_pend != '0) && ({1'b0, reg_pend} < L_NREGS);
    assign w_ok1     = (fnt1 != '0) && ({1'b0, fnt1} < L_NREGS);
    assign w_ok2     = (fnt2 != '0) && ({1'b0, fnt2} < L_NREGS);

    // Forwarding only matters when the read itself is in range; a matching
    // reg_e is then in range too, so the write really is happening.
    assign w_byp1 = BYPASS && e_l && (reg_e == fnt1);
    assign w_byp2 = BYPASS && e_l && (reg_e == fnt2);

    // Clear first, then set: when decode re-issues the register being written
    // back, the newer producer is the one still outstanding.
    always_comb begin
        w_pend_next = r_pend;
        if (w_wr_ok) begin
            w_pend_next[reg_e] = 1'b0;
        end
        if (w_mark_ok) begin
            w_pend_next[reg_pend] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_REGS; i++) begin
                r_regs[i] <= '0;
            end
            r_pend <= '0;
        end else begin
            if (w_wr_ok) begin
                r_regs[reg_e] <= dado;
            end
            r_pend <= w_pend_next;
        end
    end

    always_comb begin
        dado_l_1 = '0;
        if (w_ok1) begin
            dado_l_1 = w_byp1 ? dado : r_regs[fnt1];
        end
    end

    always_comb begin
        dado_l_2 = '0;
        if (w_ok2) begin
            dado_l_2 = w_byp2 ? dado : r_regs[fnt2];
        end
    end

    // A pending source resolved by this cycle's forwarded writeback does not stall.
    assign ocupado_1 = w_ok1 && r_pend[fnt1] && !w_byp1;
    assign ocupado_2 = w_ok2 && r_pend[fnt2] && !w_byp2;
    assign pendentes = r_pend;

endmodule

// File: tb/tb_banco_reg_param.sv
// tb/tb_banco_reg_param.sv - scoreboard bench for banco_reg_param over three configurations

module tb_banco_reg_param;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  reg_e;
    logic        e_l;
    logic [31:0] dado;
    logic [2:0]  fnt1;
    logic [2:0]  fnt2;
    logic [2:0]  reg_pend;
    logic        marca_pend;

    always #5 clk = ~clk;

    // cfg0: 8 regs bypass, cfg1: 8 regs no bypass, cfg2: 6 regs bypass
    logic [31:0] a_d1 [3];
    logic [31:0] a_d2 [3];
    logic        a_o1 [3];
    logic        a_o2 [3];
    logic [7:0]  a_pd [3];
    logic [7:0]  pd0;
    logic [7:0]  pd1;
    logic [5:0]  pd2;

    banco_reg_param #(.LARGURA(32), .N_REGS(8), .BYPASS(1'b1)) dut0 (
        .clk(clk), .rst(rst), .reg_e(reg_e), .e_l(e_l), .dado(dado),
        .fnt1(fnt1), .fnt2(fnt2), .dado_l_1(a_d1[0]), .dado_l_2(a_d2[0]),
        .reg_pend(reg_pend), .marca_pend(marca_pend),
        .ocupado_1(a_o1[0]), .ocupado_2(a_o2[0]), .pendentes(pd0));

    banco_reg_param #(.LARGURA(32), .N_REGS(8), .BYPASS(1'b0)) dut1 (
        .clk(clk), .rst(rst), .reg_e(reg_e), .e_l(e_l), .dado(dado),
        .fnt1(fnt1), .fnt2(fnt2), .dado_l_1(a_d1[1]), .dado_l_2(a_d2[1]),
        .reg_pend(reg_pend), .marca_pend(marca_pend),
        .ocupado_1(a_o1[1]), .ocupado_2(a_o2[1]), .pendentes(pd1));

    banco_reg_param #(.LARGURA(32), .N_REGS(6), .BYPASS(1'b1)) dut2 (
        .clk(clk), .rst(rst), .reg_e(reg_e), .e_l(e_l), .dado(dado),
        .fnt1(fnt1), .fnt2(fnt2), .dado_l_1(a_d1[2]), .dado_l_2(a_d2[2]),
        .reg_pend(reg_pend), .marca_pend(marca_pend),
        .ocupado_1(a_o1[2]), .ocupado_2(a_o2[2]), .pendentes(pd2));

    assign a_pd[0] = pd0;
    assign a_pd[1] = pd1;
    assign a_pd[2] = {2'b00, pd2};

    typedef struct packed {
        logic [2:0][31:0] d1;
        logic [2:0][31:0] d2;
        logic [2:0]       o1;
        logic [2:0]       o2;
        logic [2:0][7:0]  pd;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad = 0;
    int pushed = 0;
    int popped = 0;

    // Reference model: register contents and pending flags per configuration
    int          cfg_n [3] = '{8, 8, 6};
    bit          cfg_b [3] = '{1'b1, 1'b0, 1'b1};
    logic [31:0] m_mem [3][8];
    logic [7:0]  m_pend [3];

    function automatic bit m_valid(int c, logic [2:0] a);
        return (a != 3'd0) && (int'(a) < cfg_n[c]);
    endfunction

    function automatic logic [31:0] m_read(int c, logic [2:0] a, bit el, logic [2:0] re, logic [31:0] d);
        if (!m_valid(c, a)) return 32'd0;
        if (cfg_b[c] && el && re == a) return d;
        return m_mem[c][a];
    endfunction

    function automatic logic m_busy(int c, logic [2:0] a, bit el, logic [2:0] re);
        if (!m_valid(c, a)) return 1'b0;
        if (cfg_b[c] && el && re == a) return 1'b0;
        return m_pend[c][a];
    endfunction

    task automatic chk(input string nm, input int c, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cfg%0d t=%0t: got %h expected %h", nm, c, $time, act, exp);
        end
    endtask

    // Monitor: read outputs are combinational, so every driven cycle presents
    // one response, sampled mid-cycle.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            popped++;
            for (int c = 0; c < 3; c++) begin
                chk("dado_l_1", c, a_d1[c], e.d1[c]);
                chk("dado_l_2", c, a_d2[c], e.d2[c]);
                chk("ocupado_1", c, {31'd0, a_o1[c]}, {31'd0, e.o1[c]});
                chk("ocupado_2", c, {31'd0, a_o2[c]}, {31'd0, e.o2[c]});
                chk("pendentes", c, {24'd0, a_pd[c]}, {24'd0, e.pd[c]});
            end
        end
    end

    task automatic step(input bit r, input bit el, input logic [2:0] re, input logic [31:0] d,
                        input logic [2:0] f1, input logic [2:0] f2,
                        input bit mp, input logic [2:0] rp, input bit do_chk);
        exp_t e;
        rst = r; e_l = el; reg_e = re; dado = d;
        fnt1 = f1; fnt2 = f2; marca_pend = mp; reg_pend = rp;
        for (int c = 0; c < 3; c++) begin
            e.d1[c] = m_read(c, f1, el, re, d);
            e.d2[c] = m_read(c, f2, el, re, d);
            e.o1[c] = m_busy(c, f1, el, re);
            e.o2[c] = m_busy(c, f2, el, re);
            e.pd[c] = m_pend[c];
        end
        if (do_chk) begin
            q.push_back(e);
            pushed++;
        end
        for (int c = 0; c < 3; c++) begin
            if (r) begin
                for (int k = 0; k < 8; k++) m_mem[c][k] = 32'd0;
                m_pend[c] = 8'd0;
            end else begin
                if (el && m_valid(c, re)) begin
                    m_mem[c][re] = d;
                    m_pend[c][re] = 1'b0;
                end
                if (mp && m_valid(c, rp)) m_pend[c][rp] = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        // reset then read
        step(0, 0, 0, 0, 3, 7, 0, 0, 1);
        // write r5, attempt r0, read back
        step(0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 1);
        step(0, 1, 0, 32'h12345678, 5, 0, 0, 0, 1);
        step(0, 0, 0, 0, 5, 0, 0, 0, 1);
        // bypass vs. registered read
        step(0, 1, 2, 32'h11112222, 0, 0, 0, 0, 1);
        step(0, 1, 2, 32'hA5A5A5A5, 2, 2, 0, 0, 1);
        step(0, 0, 0, 0, 2, 5, 0, 0, 1);
        // scoreboard mark, hold, clear
        step(0, 0, 0, 0, 4, 0, 1, 4, 1);
        step(0, 0, 0, 0, 4, 4, 0, 0, 1);
        step(0, 1, 4, 32'h44444444, 4, 1, 0, 0, 1);
        step(0, 0, 0, 0, 4, 0, 0, 0, 1);
        // same register set and cleared together: set wins
        step(0, 0, 0, 0, 0, 0, 1, 6, 1);
        step(0, 1, 6, 32'h66666666, 6, 6, 1, 6, 1);
        step(0, 0, 0, 0, 6, 3, 0, 0, 1);
        // set and clear on different registers
        step(0, 1, 6, 32'h66660000, 3, 6, 1, 3, 1);
        step(0, 0, 0, 0, 3, 6, 0, 0, 1);
        // out-of-range addresses for the 6-register bank
        step(0, 1, 7, 32'h77777777, 7, 6, 1, 7, 1);
        step(0, 1, 6, 32'h66667777, 7, 6, 1, 6, 1);
        step(0, 0, 0, 0, 7, 6, 0, 0, 1);
        // reset discards pending, later writeback still lands
        step(0, 0, 0, 0, 0, 0, 1, 3, 1);
        step(1, 1, 5, 32'h55555555, 3, 5, 1, 2, 1);
        step(0, 1, 3, 32'h33333333, 3, 2, 0, 0, 1);
        step(0, 0, 0, 0, 3, 5, 0, 0, 1);
        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 59) == 0, $urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)), $urandom,
                 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                 $urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)), 1);
        end
        e_l = 0; marca_pend = 0; rst = 0;
        @(negedge clk);
        @(negedge clk);
        chk("drained", 0, 32'(popped), 32'(pushed));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
